// File: rtl/hex_report_tx_pkg.sv
// -----------------------------------------------------------------------------
// hex_report_tx_pkg
// Shared definitions for the hex report transmitter:
//   - ASCII control/separator constants used in the report framing
//   - hex_report_state_t, the report FSM state encoding
//   - tohex(), nibble to upper-case ASCII hex character
// -----------------------------------------------------------------------------
package hex_report_tx_pkg;

  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // ST_ prefix keeps these clear of the PREFIX parameter in the top module
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFIX,
    ST_DIGIT,
    ST_SEP,
    ST_CR,
    ST_LF
  } hex_report_state_t;

  // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
  function automatic logic [7:0] tohex(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/hex_report_tx.sv
// -----------------------------------------------------------------------------
// hex_report_tx
// Snapshot-and-report engine. On a trigger (external or periodic) it captures
// NUM_FIELDS values of FIELD_W bits and streams them as ASCII text:
//   PREFIX, hex fields (MS nibble first) separated by spaces, CR, LF.
// A one-deep pending buffer holds a snapshot taken while a report is running;
// overwriting it counts as a drop.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   trig       one-cycle capture request
//   fields     packed snapshot values, field 0 in the LSBs
//   tx_data    ASCII byte to the uart
//   tx_valid   tx_data valid
//   tx_ready   uart accepts a byte
//   busy       report in progress or pending
//   done       one-cycle pulse after the final LF is accepted
//   drop_count saturating count of discarded snapshots
// -----------------------------------------------------------------------------
module hex_report_tx
  import hex_report_tx_pkg::*;
#(
  parameter int NUM_FIELDS = 4,
  parameter int FIELD_W    = 32,
  parameter int PREFIX_LEN = 6,
  parameter logic [((PREFIX_LEN > 0) ? PREFIX_LEN : 1)*8-1:0] PREFIX = "state:",
  parameter int PERIOD     = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          trig,
  input  logic [NUM_FIELDS*FIELD_W-1:0] fields,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          busy,
  output logic                          done,
  output logic [7:0]                    drop_count
);

  localparam int DIGITS = (FIELD_W + 3) / 4;
  localparam int PAD_W  = DIGITS * 4;
  localparam int PIDX_W = (PREFIX_LEN > 1) ? $clog2(PREFIX_LEN) : 1;
  localparam int DIDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FIDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [PIDX_W-1:0] PIDX_LAST = PIDX_W'((PREFIX_LEN > 0) ? PREFIX_LEN - 1 : 0);
  localparam logic [DIDX_W-1:0] DIDX_LAST = DIDX_W'(DIGITS - 1);
  localparam logic [FIDX_W-1:0] FIDX_LAST = FIDX_W'(NUM_FIELDS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((PERIOD > 0) ? PERIOD - 1 : 0);

  // With no prefix a report starts directly on the first digit
  localparam hex_report_state_t START_STATE = (PREFIX_LEN > 0) ? ST_PREFIX : ST_DIGIT;

  hex_report_state_t state_q, state_d;

  logic [NUM_FIELDS*FIELD_W-1:0] active_q;
  logic [NUM_FIELDS*FIELD_W-1:0] pending_q;
  logic                          pending_vld_q;

  logic [PIDX_W-1:0] prefix_idx_q, prefix_idx_d;
  logic [DIDX_W-1:0] digit_idx_q, digit_idx_d;
  logic [FIDX_W-1:0] field_idx_q, field_idx_d;

  logic [CNT_W-1:0] period_cnt_q;
  logic [7:0]       drop_q;
  logic             done_q;

  logic period_hit;
  logic eff_trig;
  logic xfer;
  logic msg_end;

  logic [FIELD_W-1:0] cur_field;
  logic [PAD_W-1:0]   padded;
  logic [3:0]         nibble;
  logic [7:0]         prefix_byte;

  assign period_hit = (PERIOD > 0) && (period_cnt_q == CNT_LAST);
  assign eff_trig   = trig | period_hit;
  assign tx_valid   = (state_q != ST_IDLE);
  assign xfer       = tx_valid && tx_ready;
  assign msg_end    = (state_q == ST_LF) && xfer;
  assign busy       = tx_valid || pending_vld_q;
  assign done       = done_q;
  assign drop_count = drop_q;

  // Selects the current character; everything it depends on only moves on a
  // handshake, so tx_data is stable while the uart stalls.
  always_comb begin
    int fbase;
    int npos;
    int ppos;
    fbase       = int'(field_idx_q) * FIELD_W;
    cur_field   = active_q[fbase +: FIELD_W];
    padded      = PAD_W'(cur_field);
    npos        = (DIGITS - 1 - int'(digit_idx_q)) * 4;
    nibble      = padded[npos +: 4];
    ppos        = (PREFIX_LEN > 0) ? (PREFIX_LEN - 1 - int'(prefix_idx_q)) * 8 : 0;
    prefix_byte = PREFIX[ppos +: 8];
    tx_data     = 8'h00;
    case (state_q)
      ST_PREFIX: tx_data = prefix_byte;
      ST_DIGIT:  tx_data = tohex(nibble);
      ST_SEP:    tx_data = ASCII_SP;
      ST_CR:     tx_data = ASCII_CR;
      ST_LF:     tx_data = ASCII_LF;
      default:   tx_data = 8'h00;
    endcase
  end

  // Next-state logic; every state except IDLE advances only on a handshake
  always_comb begin
    state_d      = state_q;
    prefix_idx_d = prefix_idx_q;
    digit_idx_d  = digit_idx_q;
    field_idx_d  = field_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (eff_trig) begin
          state_d      = START_STATE;
          prefix_idx_d = '0;
          digit_idx_d  = '0;
          field_idx_d  = '0;
        end
      end
      ST_PREFIX: begin
        if (xfer) begin
          if (prefix_idx_q == PIDX_LAST) begin
            prefix_idx_d = '0;
            state_d      = ST_DIGIT;
          end else begin
            prefix_idx_d = prefix_idx_q + PIDX_W'(1);
          end
        end
      end
      ST_DIGIT: begin
        if (xfer) begin
          if (digit_idx_q == DIDX_LAST) begin
            digit_idx_d = '0;
            state_d     = (field_idx_q == FIDX_LAST) ? ST_CR : ST_SEP;
          end else begin
            digit_idx_d = digit_idx_q + DIDX_W'(1);
          end
        end
      end
      ST_SEP: begin
        if (xfer) begin
          field_idx_d = field_idx_q + FIDX_W'(1);
          state_d     = ST_DIGIT;
        end
      end
      ST_CR: begin
        if (xfer) begin
          state_d = ST_LF;
        end
      end
      ST_LF: begin
        if (xfer) begin
          field_idx_d = '0;
          state_d     = pending_vld_q ? START_STATE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and character indices
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      prefix_idx_q <= '0;
      digit_idx_q  <= '0;
      field_idx_q  <= '0;
    end else begin
      state_q      <= state_d;
      prefix_idx_q <= prefix_idx_d;
      digit_idx_q  <= digit_idx_d;
      field_idx_q  <= field_idx_d;
    end
  end

  // Snapshot capture, pending buffer and drop counting. A trigger during the
  // LF handshake lands in pending while the old pending snapshot is promoted,
  // so that case is not a drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q      <= '0;
      pending_q     <= '0;
      pending_vld_q <= 1'b0;
      drop_q        <= 8'd0;
      done_q        <= 1'b0;
    end else begin
      done_q <= msg_end;
      if (msg_end && pending_vld_q) begin
        active_q <= pending_q;
      end
      if (eff_trig && (state_q == ST_IDLE)) begin
        active_q <= fields;
      end else if (eff_trig) begin
        pending_q     <= fields;
        pending_vld_q <= 1'b1;
        if (pending_vld_q && !msg_end && (drop_q != 8'hFF)) begin
          drop_q <= drop_q + 8'd1;
        end
      end else if (msg_end) begin
        pending_vld_q <= 1'b0;
      end
    end
  end

  // Free-running auto-trigger counter, wraps on the hit cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_cnt_q <= '0;
    end else if (PERIOD > 0) begin
      if (period_hit) begin
        period_cnt_q <= '0;
      end else begin
        period_cnt_q <= period_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hex_report_tx.sv
// -----------------------------------------------------------------------------
// tb_hex_report_tx
// Directed bench for hex_report_tx with four instances:
//   dut_a  2 x 16-bit fields, prefix "p:", no auto-trigger
//   dut_b  1 x 10-bit field, no prefix
//   dut_c  as dut_a with PERIOD=100
//   dut_d  as dut_a with PERIOD=4 (drop counter saturation)
// -----------------------------------------------------------------------------
module tb_hex_report_tx;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        a_trig = 1'b0, a_tx_ready = 1'b1;
  logic [31:0] a_fields = '0;
  logic [7:0]  a_tx_data, a_drop;
  logic        a_tx_valid, a_busy, a_done;

  logic        b_trig = 1'b0, b_tx_ready = 1'b1;
  logic [9:0]  b_fields = '0;
  logic [7:0]  b_tx_data, b_drop;
  logic        b_tx_valid, b_busy, b_done;

  logic        c_tx_ready = 1'b1;
  logic [7:0]  c_tx_data, c_drop;
  logic        c_tx_valid, c_busy, c_done;

  logic        d_tx_ready = 1'b1;
  logic [7:0]  d_tx_data, d_drop;
  logic        d_tx_valid, d_busy, d_done;

  hex_report_tx #(.NUM_FIELDS(2), .FIELD_W(16), .PREFIX_LEN(2), .PREFIX("p:"), .PERIOD(0)) dut_a (
    .clk(clk), .reset(reset), .trig(a_trig), .fields(a_fields),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .busy(a_busy), .done(a_done), .drop_count(a_drop)
  );

  hex_report_tx #(.NUM_FIELDS(1), .FIELD_W(10), .PREFIX_LEN(0), .PREFIX(8'h00), .PERIOD(0)) dut_b (
    .clk(clk), .reset(reset), .trig(b_trig), .fields(b_fields),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .busy(b_busy), .done(b_done), .drop_count(b_drop)
  );

  hex_report_tx #(.NUM_FIELDS(2), .FIELD_W(16), .PREFIX_LEN(2), .PREFIX("p:"), .PERIOD(100)) dut_c (
    .clk(clk), .reset(reset), .trig(1'b0), .fields(32'h0000_0000),
    .tx_data(c_tx_data), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready),
    .busy(c_busy), .done(c_done), .drop_count(c_drop)
  );

  hex_report_tx #(.NUM_FIELDS(2), .FIELD_W(16), .PREFIX_LEN(2), .PREFIX("p:"), .PERIOD(4)) dut_d (
    .clk(clk), .reset(reset), .trig(1'b0), .fields(32'h1234_5678),
    .tx_data(d_tx_data), .tx_valid(d_tx_valid), .tx_ready(d_tx_ready),
    .busy(d_busy), .done(d_done), .drop_count(d_drop)
  );

  int checks = 0;
  int failures = 0;

  byte_q_t qa;
  byte_q_t qb;
  logic       a_stall_prev = 1'b0;
  logic [7:0] a_stall_data = 8'h00;
  logic       rand_ready = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Bytes are logged on the falling edge ahead of the accepting rising edge;
  // a stalled byte must still be offered unchanged one cycle later.
  always @(negedge clk) begin
    if (a_tx_valid && a_tx_ready) qa.push_back(a_tx_data);
    if (b_tx_valid && b_tx_ready) qb.push_back(b_tx_data);
    if (a_stall_prev) begin
      checkOutput("a_hold_valid", {31'b0, a_tx_valid}, 32'd1);
      checkOutput("a_hold_data", {24'b0, a_tx_data}, {24'b0, a_stall_data});
    end
    a_stall_prev <= a_tx_valid && !a_tx_ready;
    a_stall_data <= a_tx_data;
  end

  // Random backpressure, ready roughly one cycle in three
  always @(posedge clk) begin
    #1;
    if (rand_ready) a_tx_ready = ($urandom_range(0, 2) == 0);
  end

  function automatic byte_q_t make_msg(input string s);
    byte_q_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  task automatic compare_msg(input string tag, input byte_q_t got, input byte_q_t exp);
    checkOutput({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) checkOutput($sformatf("%s_byte%0d", tag, i), {24'b0, got[i]}, {24'b0, exp[i]});
    end
  endtask

  // One-cycle trigger; returns 1 time unit after the capturing edge
  task automatic applyStimulus(input int sel, input logic [31:0] flds);
    @(posedge clk);
    #1;
    if (sel == 0) begin a_fields = flds; a_trig = 1'b1; end
    else begin b_fields = flds[9:0]; b_trig = 1'b1; end
    @(posedge clk);
    #1;
    a_trig = 1'b0;
    b_trig = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int sel, input int max_cycles,
                           output int dones, output int gaps);
    logic bsy, vld, dn;
    logic timed_out;
    dones = 0;
    gaps = 0;
    timed_out = 1'b1;
    for (int n = 0; n < max_cycles; n++) begin
      @(negedge clk);
      bsy = (sel == 0) ? a_busy : b_busy;
      vld = (sel == 0) ? a_tx_valid : b_tx_valid;
      dn  = (sel == 0) ? a_done : b_done;
      if (dn) dones++;
      if (bsy && !vld) gaps++;
      if (!bsy) begin
        timed_out = 1'b0;
        break;
      end
    end
    checkOutput({tag, "_timeout"}, {31'b0, timed_out}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int dones, gaps;
    int starts[$];
    int cyc;
    logic prev_v;
    byte_q_t exp;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", {31'b0, a_tx_valid}, 32'd0);
    checkOutput("rst_data", {24'b0, a_tx_data}, 32'd0);
    checkOutput("rst_busy", {31'b0, a_busy}, 32'd0);
    checkOutput("rst_done", {31'b0, a_done}, 32'd0);
    checkOutput("rst_drop", {24'b0, a_drop}, 32'd0);
    reset = 1'b1;

    // Test 1: basic two-field report
    $display("[TB] test 1: basic report");
    qa.delete();
    @(posedge clk);
    #1;
    checkOutput("t1_idle_valid", {31'b0, a_tx_valid}, 32'd0);
    applyStimulus(0, {16'hBEEF, 16'h0123});
    checkOutput("t1_lat_valid", {31'b0, a_tx_valid}, 32'd1);
    checkOutput("t1_lat_data", {24'b0, a_tx_data}, 32'h70);
    checkOutput("t1_busy", {31'b0, a_busy}, 32'd1);
    wait_idle("t1", 0, 100, dones, gaps);
    checkOutput("t1_dones", dones, 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("t1_done_after", {31'b0, a_done}, 32'd0);
    checkOutput("t1_busy_after", {31'b0, a_busy}, 32'd0);
    compare_msg("t1", qa, make_msg("p:0123 BEEF"));

    // Test 3: same report under backpressure
    $display("[TB] test 3: backpressure");
    qa.delete();
    rand_ready = 1'b1;
    applyStimulus(0, {16'hBEEF, 16'h0123});
    wait_idle("t3", 0, 500, dones, gaps);
    rand_ready = 1'b0;
    a_tx_ready = 1'b1;
    checkOutput("t3_dones", dones, 32'd1);
    compare_msg("t3", qa, make_msg("p:0123 BEEF"));

    // Test 4: pending buffer and drop
    $display("[TB] test 4: triggers during a message");
    qa.delete();
    checkOutput("t4_drop_pre", {24'b0, a_drop}, 32'd0);
    applyStimulus(0, {16'h5A00, 16'h00A5});
    repeat (2) @(posedge clk);
    applyStimulus(0, {16'hBEEF, 16'hDEAD});
    repeat (2) @(posedge clk);
    applyStimulus(0, {16'h0042, 16'hCAFE});
    wait_idle("t4", 0, 200, dones, gaps);
    checkOutput("t4_dones", dones, 32'd2);
    checkOutput("t4_gaps", gaps, 32'd0);
    checkOutput("t4_drop", {24'b0, a_drop}, 32'd1);
    exp = make_msg("p:00A5 5A00");
    exp = {exp, make_msg("p:CAFE 0042")};
    compare_msg("t4", qa, exp);

    // Test 2: 10-bit field, no prefix
    $display("[TB] test 2: odd width, no prefix");
    qb.delete();
    applyStimulus(1, 32'h0000_03FF);
    checkOutput("t2_lat_valid", {31'b0, b_tx_valid}, 32'd1);
    checkOutput("t2_lat_data", {24'b0, b_tx_data}, 32'h33);
    wait_idle("t2a", 1, 100, dones, gaps);
    checkOutput("t2a_dones", dones, 32'd1);
    compare_msg("t2a", qb, make_msg("3FF"));
    qb.delete();
    applyStimulus(1, 32'h0000_0001);
    wait_idle("t2b", 1, 100, dones, gaps);
    compare_msg("t2b", qb, make_msg("001"));

    // Test 5: periodic auto-trigger and drop saturation
    $display("[TB] test 5: auto-trigger");
    prev_v = c_tx_valid;
    for (cyc = 0; cyc < 350; cyc++) begin
      @(negedge clk);
      if (c_tx_valid && !prev_v) starts.push_back(cyc);
      prev_v = c_tx_valid;
    end
    checkOutput("t5_starts", {31'b0, starts.size() >= 3}, 32'd1);
    if (starts.size() >= 3) begin
      checkOutput("t5_interval1", starts[1] - starts[0], 32'd100);
      checkOutput("t5_interval2", starts[2] - starts[1], 32'd100);
    end
    checkOutput("t5_c_drop", {24'b0, c_drop}, 32'd0);
    for (cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (d_drop == 8'hFF) break;
    end
    checkOutput("t5_sat", {24'b0, d_drop}, 32'hFF);
    repeat (40) @(negedge clk);
    checkOutput("t5_sat_hold", {24'b0, d_drop}, 32'hFF);
    checkOutput("t5_d_busy", {31'b0, d_busy}, 32'd1);

    // Test 6: reset mid-prefix
    $display("[TB] test 6: reset mid-message");
    applyStimulus(0, {16'h1111, 16'h2222});
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("t6_valid", {31'b0, a_tx_valid}, 32'd0);
    checkOutput("t6_drop", {24'b0, a_drop}, 32'd0);
    checkOutput("t6_busy", {31'b0, a_busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t6_quiet", {31'b0, a_tx_valid}, 32'd0);
    qa.delete();
    applyStimulus(0, {16'hABCD, 16'h1234});
    wait_idle("t6", 0, 100, dones, gaps);
    checkOutput("t6_dones", dones, 32'd1);
    compare_msg("t6", qa, make_msg("p:1234 ABCD"));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
